// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: size encodings, FSM states and lane helpers shared by the load/store unit.
package lsu_pkg;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, ERR} state_t;
    function automatic logic [1:0] eff_size(input logic [1:0] size, input int xlen);
        return (size == SZ_D && xlen == 32) ? SZ_W : size;
    endfunction
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        return 3'((4'd1 << size) - 4'd1);
    endfunction
    // One bit per byte of the access, shifted up to the starting lane.
    function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] off);
        logic [15:0] m;
        m = 16'((9'd1 << (4'd1 << size)) - 9'd1) << off;
        return m[7:0];
    endfunction
endpackage

// File: rtl/load_store_unit_aligner.sv
// load_aligner: shifts the addressed lane down and sign/zero-extends it to XLEN.
module load_aligner
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              rdata,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    input  logic [1:0]                   size,
    input  logic                         is_unsigned,
    output logic [XLEN-1:0]              result
);
    logic [XLEN-1:0] shifted, mask;
    logic [6:0] nbits;
    logic sign;
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        nbits = 7'd8 << eff_size(size, XLEN);
        mask = ~({XLEN{1'b1}} << nbits);
        sign = ~is_unsigned & |(shifted & mask & ~(mask >> 1));
        result = sign ? (shifted | ~mask) : (shifted & mask);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store FSM with valid/ready memory port.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_store,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [XLEN-1:0]     req_base,
    input  logic [IMM_W-1:0]    req_imm,
    input  logic [REG_AW-1:0]   req_rd,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                wb_valid,
    output logic [REG_AW-1:0]   wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                st_done,
    output logic                err
);
    localparam int LB = $clog2(XLEN/8);
    state_t state;
    logic [1:0] size_q, sz;
    logic uns_q, trap;
    logic [REG_AW-1:0] rd_q;
    logic [LB-1:0] off_q;
    logic [XLEN-1:0] sum, rep, ld_data;
    logic [ADDR_W-1:0] ea_raw, ea;
    logic [7:0] be8;
    always_comb begin
        sz = eff_size(req_size, XLEN);
        sum = req_base + {{(XLEN-IMM_W){req_imm[IMM_W-1]}}, req_imm};
        ea_raw = sum[ADDR_W-1:0];
        rep = '0;
        for (int i = 0; i < XLEN/8; i++) rep[8*i +: 8] = req_wdata[8*(i % (1 << sz)) +: 8];
    end
`ifdef MISALIGN_TRAP_EN
    assign ea = ea_raw;
    assign trap = |(ea_raw[2:0] & align_mask(sz));
`else
    assign ea = ea_raw & ~ADDR_W'(align_mask(sz));
    assign trap = 1'b0;
`endif
    assign be8 = byte_en(sz, 3'(ea[LB-1:0]));
    assign req_ready = state == IDLE && !reset;
    load_aligner #(.XLEN(XLEN)) u_aligner (
        .rdata(mem_rdata), .offset(off_q), .size(size_q), .is_unsigned(uns_q), .result(ld_data)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            size_q <= '0;
            uns_q <= 1'b0;
            rd_q <= '0;
            off_q <= '0;
            mem_req_valid <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_be <= '0;
            mem_wdata <= '0;
            wb_valid <= 1'b0;
            wb_rd <= '0;
            wb_data <= '0;
            st_done <= 1'b0;
            err <= 1'b0;
        end else begin
            st_done <= 1'b0;
            wb_valid <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    size_q <= sz;
                    uns_q <= req_unsigned;
                    rd_q <= req_rd;
                    off_q <= ea[LB-1:0];
                    mem_we <= req_store;
                    mem_addr <= ea;
                    mem_be <= be8[XLEN/8-1:0];
                    mem_wdata <= rep;
                    mem_req_valid <= !trap;
                    err <= trap;
                    state <= trap ? ERR : ISSUE;
                end
                ISSUE: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    st_done <= mem_we;
                    state <= mem_we ? IDLE : WAIT;
                end
                WAIT: if (mem_rsp_valid) begin
                    wb_valid <= 1'b1;
                    wb_rd <= rd_q;
                    wb_data <= ld_data;
                    state <= WB;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
